// File: rtl/dti_pr_async_ctrl.sv
// Partial-reset sequencer for the DTI PR async-FIFO pair: stall at packet boundaries, drain, clear, handshake done.
// Optional drain timeout with forced flush is enabled by defining DTI_PR_CTRL_TIMEOUT_EN.
module dti_pr_async_ctrl #(
  parameter int CLEAR_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic partial_reset,
  output logic pr_done,
  output logic pr_err,
  output logic idle,
  input  logic req_vld,
  input  logic req_rdy,
  input  logic req_last,
  input  logic rsp_vld,
  input  logic rsp_rdy,
  input  logic rsp_last,
  output logic req_stall,
  output logic req_clear,
  input  logic req_full_zero,
  output logic rsp_stall,
  output logic rsp_clear,
  input  logic rsp_full_zero,
  input  logic rsp_afifo_idle
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_STALL = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15 || DRAIN_TIMEOUT < 2) begin : g_param_err
    $error("dti_pr_async_ctrl: CLEAR_CYCLES must be 1..15 and DRAIN_TIMEOUT >= 2");
  end

  logic [2:0] state_q, state_d;
  logic       req_in_pkt_q, req_in_pkt_d;
  logic       rsp_in_pkt_q, rsp_in_pkt_d;
  logic       req_stall_q, req_stall_d;
  logic       rsp_stall_q, rsp_stall_d;
  logic       clear_q, clear_d;
  logic       pr_done_q, pr_done_d;
  logic       pr_err_q, pr_err_d;
  logic       idle_q, idle_d;
  logic [3:0] clr_cnt_q, clr_cnt_d;
  logic       drained;
  logic       timeout;

  assign drained = req_full_zero & rsp_full_zero & rsp_afifo_idle;

`ifdef DTI_PR_CTRL_TIMEOUT_EN
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

  // Counter is zero on the first DRAIN cycle, so the limit hits on cycle DRAIN_TIMEOUT.
  always_comb begin
    drain_cnt_d = '0;
    if (state_q == ST_DRAIN) drain_cnt_d = drain_cnt_q + 1'b1;
  end

  assign timeout = (state_q == ST_DRAIN) && (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) drain_cnt_q <= '0;
    else        drain_cnt_q <= drain_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    req_in_pkt_d = (req_vld & req_rdy) ? ~req_last : req_in_pkt_q;
    rsp_in_pkt_d = (rsp_vld & rsp_rdy) ? ~rsp_last : rsp_in_pkt_q;

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pr_err_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (partial_reset) state_d = ST_STALL;
      ST_STALL: if (req_stall_q && rsp_stall_q) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (drained || timeout) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = 4'(CLEAR_CYCLES - 1);
          pr_err_d  = ~drained;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == 4'd0) state_d = ST_DONE;
        else                   clr_cnt_d = clr_cnt_q - 4'd1;
      end
      ST_DONE:  if (!partial_reset) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Stall only once the channel sits between packets; it sticks until the sequence ends.
    req_stall_d = 1'b0;
    rsp_stall_d = 1'b0;
    if (state_d != ST_IDLE) begin
      req_stall_d = req_stall_q | ((state_q != ST_IDLE) & ~req_in_pkt_d);
      rsp_stall_d = rsp_stall_q | ((state_q != ST_IDLE) & ~rsp_in_pkt_d);
    end

    clear_d   = (state_d == ST_CLEAR);
    pr_done_d = (state_d == ST_DONE);
    idle_d    = (state_q == ST_IDLE) & ~req_in_pkt_q & ~rsp_in_pkt_q & drained;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_in_pkt_q <= 1'b0;
      rsp_in_pkt_q <= 1'b0;
      req_stall_q  <= 1'b0;
      rsp_stall_q  <= 1'b0;
      clear_q      <= 1'b0;
      pr_done_q    <= 1'b0;
      pr_err_q     <= 1'b0;
      idle_q       <= 1'b0;
      clr_cnt_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      req_in_pkt_q <= req_in_pkt_d;
      rsp_in_pkt_q <= rsp_in_pkt_d;
      req_stall_q  <= req_stall_d;
      rsp_stall_q  <= rsp_stall_d;
      clear_q      <= clear_d;
      pr_done_q    <= pr_done_d;
      pr_err_q     <= pr_err_d;
      idle_q       <= idle_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  assign req_stall = req_stall_q;
  assign rsp_stall = rsp_stall_q;
  assign req_clear = clear_q;
  assign rsp_clear = clear_q;
  assign pr_done   = pr_done_q;
  assign pr_err    = pr_err_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_dti_pr_async_ctrl.sv
// Bench for dti_pr_async_ctrl: directed latency scenarios plus randomized traffic against a phase-level reference model.
module tb_dti_pr_async_ctrl;

  localparam int CC = 2;
  localparam int DT = 16;
`ifdef DTI_PR_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, partial_reset;
  logic pr_done, pr_err, idle;
  logic req_vld, req_rdy, req_last, rsp_vld, rsp_rdy, rsp_last;
  logic req_stall, req_clear, rsp_stall, rsp_clear;
  logic req_full_zero, rsp_full_zero, rsp_afifo_idle;

  always #5 clk = ~clk;

  dti_pr_async_ctrl #(.CLEAR_CYCLES(CC), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst_n(rst_n), .partial_reset(partial_reset),
    .pr_done(pr_done), .pr_err(pr_err), .idle(idle),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_last(req_last),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_last(rsp_last),
    .req_stall(req_stall), .req_clear(req_clear), .req_full_zero(req_full_zero),
    .rsp_stall(rsp_stall), .rsp_clear(rsp_clear), .rsp_full_zero(rsp_full_zero),
    .rsp_afifo_idle(rsp_afifo_idle)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sequence phase plus per-channel packet/stall bookkeeping.
  // Phases: 0 idle, 1 waiting for boundaries, 2 draining, 3 clearing, 4 done.
  int m_ph = 0, m_left = 0, m_dn = 0;
  bit m_rpk = 0, m_spk = 0, m_rst = 0, m_sst = 0;
  bit e_rs = 0, e_ss = 0, e_clr = 0, e_done = 0, e_err = 0, e_idle = 0;

  task automatic model_step();
    bit rn, sn, empty;
    int old_ph;
    if (!rst_n) begin
      m_ph = 0; m_left = 0; m_dn = 0;
      m_rpk = 0; m_spk = 0; m_rst = 0; m_sst = 0;
      e_err = 0; e_idle = 0;
    end else begin
      rn = (req_vld && req_rdy) ? !req_last : m_rpk;
      sn = (rsp_vld && rsp_rdy) ? !rsp_last : m_spk;
      empty = req_full_zero && rsp_full_zero && rsp_afifo_idle;
      e_idle = (m_ph == 0) && !m_rpk && !m_spk && empty;
      e_err = 0;
      old_ph = m_ph;
      case (m_ph)
        0: if (partial_reset) m_ph = 1;
        1: if (m_rst && m_sst) begin m_ph = 2; m_dn = 0; end
        2: begin
          m_dn++;
          if (empty) begin m_ph = 3; m_left = CC; end
          else if (TO_EN && m_dn == DT) begin m_ph = 3; m_left = CC; e_err = 1; end
        end
        3: begin m_left--; if (m_left == 0) m_ph = 4; end
        default: if (!partial_reset) m_ph = 0;
      endcase
      if (m_ph == 0) begin
        m_rst = 0; m_sst = 0;
      end else if (old_ph != 0) begin
        if (!rn) m_rst = 1;
        if (!sn) m_sst = 1;
      end
      m_rpk = rn; m_spk = sn;
    end
    e_rs = m_rst; e_ss = m_sst;
    e_clr = (m_ph == 3); e_done = (m_ph == 4);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("req_stall", req_stall, e_rs);
    chk("rsp_stall", rsp_stall, e_ss);
    chk("req_clear", req_clear, e_clr);
    chk("rsp_clear", rsp_clear, e_clr);
    chk("pr_done", pr_done, e_done);
    chk("pr_err", pr_err, e_err);
    chk("idle", idle, e_idle);
  endtask

  task automatic quiet();
    req_vld = 0; req_rdy = 1; req_last = 0;
    rsp_vld = 0; rsp_rdy = 1; rsp_last = 0;
    req_full_zero = 1; rsp_full_zero = 1; rsp_afifo_idle = 1;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!pr_done && k < limit) begin tick(); k++; end
    chk("wait_done_bound", pr_done, 1'b1);
  endtask

  task automatic finish_seq();
    wait_done(300);
    partial_reset = 0;
    tick();
    chk("release_done", pr_done, 1'b0);
    chk("release_stalls", {req_stall, rsp_stall}, 2'b00);
  endtask

  // Idle-path latencies relative to the cycle partial_reset is raised.
  task automatic idle_seq();
    partial_reset = 1;
    tick(); chk("lat_stall_p1", {req_stall, rsp_stall}, 2'b00);
    tick(); chk("lat_stall_p2", {req_stall, rsp_stall}, 2'b11);
    tick(); chk("lat_clear_p3", req_clear, 1'b0);
    for (int k = 0; k < CC; k++) begin
      tick();
      chk("lat_clear_on", {req_clear, rsp_clear}, 2'b11);
      chk("lat_done_early", pr_done, 1'b0);
    end
    tick();
    chk("lat_done", pr_done, 1'b1);
    chk("lat_clear_off", req_clear, 1'b0);
    chk("lat_stall_hold", {req_stall, rsp_stall}, 2'b11);
    repeat (4) tick();
    partial_reset = 0;
    tick();
    chk("rel_done", pr_done, 1'b0);
    chk("rel_stall", {req_stall, rsp_stall}, 2'b00);
  endtask

  initial begin
    rst_n = 0; partial_reset = 0;
    quiet();
    tick(); tick();
    chk("rst_outputs", {req_stall, rsp_stall, req_clear, rsp_clear, pr_done, pr_err, idle}, 7'd0);
    rst_n = 1;
    repeat (3) tick();
    chk("idle_high", idle, 1'b1);

    // Idle path, then back-to-back repeat one cycle after returning to idle.
    idle_seq();
    tick();
    idle_seq();

    // Mid-packet: 4-beat request packet, partial_reset raised with beat 2.
    repeat (3) tick();
    req_vld = 1; req_rdy = 1; req_last = 0;
    tick();
    partial_reset = 1;
    tick();
    tick();
    chk("mid_rsp_stall", rsp_stall, 1'b1);
    chk("mid_req_hold", req_stall, 1'b0);
    req_last = 1;
    tick();
    chk("mid_req_stall", req_stall, 1'b1);
    quiet();
    finish_seq();

`ifdef DTI_PR_CTRL_TIMEOUT_EN
    // Drain never completes: forced flush with an error pulse.
    repeat (2) tick();
    req_full_zero = 0;
    partial_reset = 1;
    repeat (DT + 2) tick();
    chk("to_no_err_yet", pr_err, 1'b0);
    tick();
    chk("to_err", pr_err, 1'b1);
    chk("to_clear", req_clear, 1'b1);
    tick();
    chk("to_err_pulse", pr_err, 1'b0);
    quiet();
    finish_seq();
`else
    // Drain wait: req FIFO not empty for 50 cycles after stalls.
    repeat (2) tick();
    req_full_zero = 0;
    partial_reset = 1;
    repeat (52) tick();
    chk("drain_hold", req_clear, 1'b0);
    chk("drain_no_err", pr_err, 1'b0);
    req_full_zero = 1;
    tick();
    chk("drain_clear", req_clear, 1'b1);
    finish_seq();
`endif

    // Reset during CLEAR with a response packet open.
    repeat (2) tick();
    rsp_vld = 1; rsp_rdy = 1; rsp_last = 0;
    tick();
    rsp_vld = 0;
    partial_reset = 1;
    rsp_vld = 1; rsp_last = 1;
    tick();
    rsp_vld = 0; rsp_last = 0;
    repeat (3) tick();
    chk("mc_clear_on", req_clear, 1'b1);
    rst_n = 0; partial_reset = 0;
    tick();
    chk("mc_rst_outputs", {req_stall, rsp_stall, req_clear, rsp_clear, pr_done, pr_err, idle}, 7'd0);
    rst_n = 1;
    tick(); tick();
    chk("mc_idle_back", idle, 1'b1);

    // Randomized traffic and requests.
    for (int c = 0; c < 4000; c++) begin
      req_vld = ($urandom_range(0, 2) != 0);
      req_rdy = ($urandom_range(0, 3) != 0);
      req_last = ($urandom_range(0, 3) == 0);
      rsp_vld = ($urandom_range(0, 2) != 0);
      rsp_rdy = ($urandom_range(0, 3) != 0);
      rsp_last = ($urandom_range(0, 3) == 0);
      req_full_zero = ($urandom_range(0, 5) != 0);
      rsp_full_zero = ($urandom_range(0, 5) != 0);
      rsp_afifo_idle = ($urandom_range(0, 7) != 0);
      if (!partial_reset && $urandom_range(0, 19) == 0) partial_reset = 1;
      else if (partial_reset && pr_done && $urandom_range(0, 2) == 0) partial_reset = 0;
      else if (partial_reset && !pr_done && $urandom_range(0, 99) == 0) partial_reset = 0;
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
